config_access_sync: RTL and testbench
=====================================

// Module: config_access_sync
// PURPOSE
//  Successor to the fixed 4-bit config-access BEL: exports NoConfigBits tile config bits to fabric-top
//  EXTERNAL pins, but retimed into UserCLK, frozen while reconfiguration is active, debounced, and
//  readable back serially. Sits in W_IO-style tiles; drives user logic outside the fabric.
// PARAMETERS
//  NoConfigBits   8   number of config bits / external outputs (1..32)
//  SYNC_STAGES    2   synchroniser depth for ConfigBits and CfgActive (>=2)
//  STABLE_CYCLES  4   consecutive equal synced samples required before C_bit updates (1..255)
//  RESET_VALUE    0   NoConfigBits-wide value loaded into C_bit on reset
// PORTS
//  UserCLK     in   1    fabric user clock; all state on rising edge
//  Reset       in   1    asynchronous, active-high reset
//  ConfigBits  in   N    from config latches; asynchronous to UserCLK
//  CfgActive   in   1    high while a configuration frame write is in progress; asynchronous
//  C_bit       out  N    EXTERNAL; config bit i drives C_bit[i]
//  C_changed   out  1    one-cycle pulse when C_bit takes a new differing value
//  ser_start   in   1    request a serial readback snapshot of C_bit
//  ser_data    out  1    readback bit, LSB first
//  ser_valid   out  1    ser_data is valid this cycle
//  ser_last    out  1    high with the final (MSB) readback bit
// BEHAVIOUR
//  Reset (async assert, sync release): C_bit=RESET_VALUE; C_changed, ser_* =0; synchronisers=0;
//   stable counter=0; FSM=IDLE. Reset mid-readback aborts it with no further valid bits.
//  Sync: ConfigBits and CfgActive each pass SYNC_STAGES flops -> cb_s, act_s.
//  Stability: cb_prev registers cb_s. If cb_s!=cb_prev or act_s=1 -> cnt=0; else cnt saturates at
//   STABLE_CYCLES. When cnt==STABLE_CYCLES and act_s=0 and cb_s!=C_bit -> C_bit<=cb_s next edge,
//   C_changed=1 for exactly that cycle. No update while act_s=1 (outputs hold last value).
//  Latency: input change with CfgActive low reaches C_bit after SYNC_STAGES+STABLE_CYCLES+1 cycles.
//  Bits are not individually filtered: any bit toggling restarts the count for the whole word.
//  Readback FSM states IDLE, SHIFT:
//   IDLE: ser_valid=0. ser_start=1 -> shreg<=C_bit (value before any same-cycle update), idx<=0,
//         -> SHIFT.
//   SHIFT: ser_valid=1, ser_data=shreg[0], ser_last=(idx==N-1); each cycle shreg>>=1, idx++;
//         after the ser_last cycle -> IDLE. ser_start ignored in SHIFT.
//   ser_start at edge t -> first valid bit in cycle t+1; N valid cycles, contiguous, no stalls.
//   C_bit updates during SHIFT do not alter the snapshot. Back-to-back: ser_start held high gives
//   one IDLE cycle between readbacks.
//  N=1: ser_last asserted with the single valid bit.
//  Widths: idx and cnt sized by clog2; cnt must not wrap.
// STRUCTURE
//  Shared package/header cfg_access_pkg: FSM state encoding (IDLE=0, SHIFT=1), clog2 function.
//  Sub-module cfg_sync: W-bit, SYNC_STAGES-deep synchroniser with async reset; instantiated for
//   ConfigBits (W=N) and CfgActive (W=1). Filter and FSM live in the top.
//  The BEL map lists C_bit[i] <- config bit i for i=0..N-1.
// TESTING
//  1 Reset: Reset=1 async mid-cycle with RESET_VALUE=8'hA5 -> C_bit=8'hA5 immediately;
//    ser_valid=0, C_changed=0.
//  2 Update: CfgActive=0, ConfigBits 8'h00->8'h3C -> C_bit=8'h3C exactly 2+4+1=7 cycles later;
//    C_changed high 1 cycle.
//  3 Freeze: CfgActive=1, ConfigBits toggles 8'h11/8'h22 for 20 cycles then settles 8'h22 and
//    CfgActive=0 -> C_bit unchanged during freeze, becomes 8'h22 after the filter latency.
//  4 Glitch: ConfigBits pulses 8'hFF for 2 cycles then returns -> C_bit never changes, no C_changed.
//  5 Readback: C_bit=8'hB4, ser_start pulse -> 8 valid bits 0,0,1,0,1,1,0,1; ser_last on the 8th;
//    mid-stream update to 8'h00 does not alter the stream.
//  6 Reset mid-SHIFT after 3 bits -> ser_valid=0 next cycle; new ser_start gives a full 8-bit stream.

Source files
------------

// File: rtl/config_access_sync_pkg.sv
// -----------------------------------------------------------------------------
// cfg_access_pkg
// Shared definitions for the config_access_sync slice:
//   rb_state_e : readback FSM state encoding (IDLE=0, SHIFT=1)
//   clog2      : ceiling log2, used to size the index and stability counters
// -----------------------------------------------------------------------------
package cfg_access_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } rb_state_e;

    // Number of bits needed to hold values 0..value-1 (returns 0 for value<=1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((32'sd1 <<< r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/config_access_sync_if.sv
// -----------------------------------------------------------------------------
// config_access_sync_if
// Groups the config-bit inputs, exported config outputs and the serial
// readback handshake of config_access_sync.
//   master : environment side (drives ConfigBits, CfgActive, ser_start)
//   slave  : config_access_sync side (drives C_bit, C_changed, ser_*)
// -----------------------------------------------------------------------------
interface config_access_sync_if #(
    parameter int NoConfigBits = 8
);
    logic [NoConfigBits-1:0] ConfigBits;
    logic                    CfgActive;
    logic [NoConfigBits-1:0] C_bit;
    logic                    C_changed;
    logic                    ser_start;
    logic                    ser_data;
    logic                    ser_valid;
    logic                    ser_last;

    modport master (
        output ConfigBits, CfgActive, ser_start,
        input  C_bit, C_changed, ser_data, ser_valid, ser_last
    );

    modport slave (
        input  ConfigBits, CfgActive, ser_start,
        output C_bit, C_changed, ser_data, ser_valid, ser_last
    );
endinterface

// File: rtl/config_access_sync_cfg_sync.sv
// -----------------------------------------------------------------------------
// cfg_sync
// W-bit multi-flop synchroniser bringing an asynchronous word into i_clk.
// No filtering here; a multi-bit word may be captured mid-transition, which
// the stability filter downstream tolerates.
// Ports:
//   i_clk  in  1   destination clock
//   i_rst  in  1   asynchronous active-high reset (clears all stages)
//   i_d    in  W   asynchronous input
//   o_q    out W   synchronised output (last stage)
// -----------------------------------------------------------------------------
module cfg_sync #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_stage [STAGES];

    // Synchroniser shift chain.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/config_access_sync.sv
// -----------------------------------------------------------------------------
// config_access_sync
// Exports NoConfigBits tile config bits to external pins, retimed into UserCLK,
// frozen while a configuration write is active, debounced, and readable back
// serially (LSB first).
// Ports:
//   UserCLK  in  1      fabric user clock, rising edge
//   Reset    in  1      asynchronous active-high reset (released synchronously)
//   bus      slave      ConfigBits/CfgActive in, C_bit/C_changed out,
//                       ser_start in, ser_data/ser_valid/ser_last out
// C_bit[i] is driven by config bit i.
// -----------------------------------------------------------------------------
module config_access_sync
    import cfg_access_pkg::*;
#(
    parameter int                    NoConfigBits  = 8,
    parameter int                    SYNC_STAGES   = 2,
    parameter int                    STABLE_CYCLES = 4,
    parameter logic [NoConfigBits-1:0] RESET_VALUE = '0
) (
    input  logic                 UserCLK,
    input  logic                 Reset,
    config_access_sync_if.slave  bus
);

    localparam int IDX_W = (clog2(NoConfigBits) < 1) ? 1 : clog2(NoConfigBits);
    localparam int CNT_W = (clog2(STABLE_CYCLES + 1) < 1) ? 1 : clog2(STABLE_CYCLES + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NoConfigBits - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);

    logic [1:0]              r_rst_sync;
    logic                    w_rst;
    logic [NoConfigBits-1:0] w_cb_s;
    logic [0:0]              w_act_s;
    logic [NoConfigBits-1:0] r_cb_prev;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_next;
    logic                    w_stable;
    logic                    w_update;
    logic [NoConfigBits-1:0] r_c_bit;
    logic                    r_c_changed;
    rb_state_e               r_state;
    rb_state_e               w_state_next;
    logic [NoConfigBits-1:0] r_shreg;
    logic [IDX_W-1:0]        r_idx;
    logic                    w_start;
    logic                    w_ser_valid;
    logic                    w_ser_data;
    logic                    w_ser_last;

    // Reset bridge: asserts immediately, releases two UserCLK edges later.
    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            r_rst_sync <= 2'b11;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b0};
        end
    end

    assign w_rst = r_rst_sync[1];

    cfg_sync #(.W(NoConfigBits), .STAGES(SYNC_STAGES)) u_sync_cb (
        .i_clk (UserCLK),
        .i_rst (w_rst),
        .i_d   (bus.ConfigBits),
        .o_q   (w_cb_s)
    );

    cfg_sync #(.W(1), .STAGES(SYNC_STAGES)) u_sync_act (
        .i_clk (UserCLK),
        .i_rst (w_rst),
        .i_d   (bus.CfgActive),
        .o_q   (w_act_s)
    );

    // Stability filter: count consecutive cycles of an unchanged synced word
    // with CfgActive low. The update fires on the edge where the count
    // reaches STABLE_CYCLES, so a change reaches C_bit after
    // SYNC_STAGES + STABLE_CYCLES + 1 edges.
    always_comb begin
        w_stable   = (w_cb_s == r_cb_prev) && !w_act_s[0];
        w_cnt_next = '0;
        if (w_stable) begin
            if (r_cnt == CNT_MAX) begin
                w_cnt_next = r_cnt;
            end else begin
                w_cnt_next = r_cnt + CNT_W'(1);
            end
        end else begin
            w_cnt_next = '0;
        end
        w_update = w_stable && (w_cnt_next == CNT_MAX) && (w_cb_s != r_c_bit);
    end

    // Filter state and exported config outputs.
    always_ff @(posedge UserCLK or posedge w_rst) begin
        if (w_rst) begin
            r_cb_prev   <= '0;
            r_cnt       <= '0;
            r_c_bit     <= RESET_VALUE;
            r_c_changed <= 1'b0;
        end else begin
            r_cb_prev   <= w_cb_s;
            r_cnt       <= w_cnt_next;
            r_c_changed <= w_update;
            if (w_update) begin
                r_c_bit <= w_cb_s;
            end else begin
                r_c_bit <= r_c_bit;
            end
        end
    end

    assign w_start = bus.ser_start;

    // Readback FSM state register.
    always_ff @(posedge UserCLK or posedge w_rst) begin
        if (w_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Readback FSM next state and output decode; ser_start is ignored in SHIFT.
    always_comb begin
        w_state_next = r_state;
        w_ser_valid  = 1'b0;
        w_ser_data   = 1'b0;
        w_ser_last   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_next = ST_SHIFT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                w_ser_valid = 1'b1;
                w_ser_data  = r_shreg[0];
                w_ser_last  = (r_idx == IDX_LAST);
                if (r_idx == IDX_LAST) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_SHIFT;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Snapshot and shift register. The snapshot takes r_c_bit as it is
    // before any update landing on the same edge.
    always_ff @(posedge UserCLK or posedge w_rst) begin
        if (w_rst) begin
            r_shreg <= '0;
            r_idx   <= '0;
        end else if ((r_state == ST_IDLE) && w_start) begin
            r_shreg <= r_c_bit;
            r_idx   <= '0;
        end else if (r_state == ST_SHIFT) begin
            r_shreg <= r_shreg >> 1;
            r_idx   <= r_idx + IDX_W'(1);
        end else begin
            r_shreg <= r_shreg;
            r_idx   <= r_idx;
        end
    end

    assign bus.C_bit     = r_c_bit;
    assign bus.C_changed = r_c_changed;
    assign bus.ser_valid = w_ser_valid;
    assign bus.ser_data  = w_ser_data;
    assign bus.ser_last  = w_ser_last;

endmodule

// File: tb/tb_config_access_sync.sv
// -----------------------------------------------------------------------------
// tb_config_access_sync
// Self-checking bench for config_access_sync (N=8, 2 sync stages, 4 stable
// cycles, reset value 8'hA5). Inputs are driven 1 ns after the rising edge
// and outputs are sampled at that same point, before the next drive.
// -----------------------------------------------------------------------------
module tb_config_access_sync;

    localparam int N = 8;
    localparam int S = 4;
    localparam logic [7:0] RV = 8'hA5;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    config_access_sync_if #(.NoConfigBits(N)) bus ();

    config_access_sync #(
        .NoConfigBits  (N),
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (S),
        .RESET_VALUE   (RV)
    ) dut (
        .UserCLK (clk),
        .Reset   (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] cfg;
        logic       act;
        int         hold;
        logic [7:0] exp_c;
        int         exp_pulses;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold inputs for a number of cycles, returning how many C_changed pulses occurred.
    task automatic hold_cycles(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (bus.C_changed === 1'b1) pulses++;
        end
    endtask

    // Start a readback (ser_start sampled on the next edge) and check a full stream.
    task automatic check_stream(input logic [7:0] snap, input string name);
        bus.ser_start = 1'b1;
        for (int i = 0; i < N; i++) begin
            step();
            bus.ser_start = 1'b0;
            chk({name, "_valid"}, {31'd0, bus.ser_valid}, 32'd1);
            chk({name, "_data"},  {31'd0, bus.ser_data},  {31'd0, snap[i]});
            chk({name, "_last"},  {31'd0, bus.ser_last},  (i == N-1) ? 32'd1 : 32'd0);
        end
        step();
        chk({name, "_idle"}, {31'd0, bus.ser_valid}, 32'd0);
    endtask

    // Random-phase reference model: history of (ConfigBits, CfgActive) per edge.
    logic [7:0] in_h [$];
    logic       act_h [$];
    logic [7:0] model_c;

    initial begin
        int         pulses;
        logic [7:0] snap;
        logic [7:0] pool [4];
        int         hold_left;
        int         act_left;
        logic [7:0] cur_v;
        logic       upd;
        int         k;

        n_checks = 0;
        n_fail   = 0;
        rst            = 1'b1;
        bus.ConfigBits = 8'h00;
        bus.CfgActive  = 1'b0;
        bus.ser_start  = 1'b0;

        vecs[0] = '{cfg: 8'h00, act: 1'b0, hold: 12, exp_c: 8'h00, exp_pulses: 1};
        vecs[1] = '{cfg: 8'h3C, act: 1'b0, hold: 6,  exp_c: 8'h00, exp_pulses: 0};
        vecs[2] = '{cfg: 8'h3C, act: 1'b0, hold: 6,  exp_c: 8'h3C, exp_pulses: 1};
        vecs[3] = '{cfg: 8'h11, act: 1'b1, hold: 4,  exp_c: 8'h3C, exp_pulses: 0};
        vecs[4] = '{cfg: 8'h22, act: 1'b1, hold: 4,  exp_c: 8'h3C, exp_pulses: 0};
        vecs[5] = '{cfg: 8'h22, act: 1'b0, hold: 5,  exp_c: 8'h3C, exp_pulses: 0};
        vecs[6] = '{cfg: 8'h22, act: 1'b0, hold: 3,  exp_c: 8'h22, exp_pulses: 1};
        vecs[7] = '{cfg: 8'hFF, act: 1'b0, hold: 2,  exp_c: 8'h22, exp_pulses: 0};
        vecs[8] = '{cfg: 8'h22, act: 1'b0, hold: 12, exp_c: 8'h22, exp_pulses: 0};
        vecs[9] = '{cfg: 8'h81, act: 1'b0, hold: 12, exp_c: 8'h81, exp_pulses: 1};

        // Power-on reset.
        repeat (3) step();
        chk("por_cbit", {24'd0, bus.C_bit}, {24'd0, RV});
        rst = 1'b0;
        step();
        chk("por_cbit_rel",  {24'd0, bus.C_bit}, {24'd0, RV});
        chk("por_valid",     {31'd0, bus.ser_valid}, 32'd0);
        chk("por_changed",   {31'd0, bus.C_changed}, 32'd0);

        // Table-driven filter vectors.
        for (int v = 0; v < 10; v++) begin
            bus.ConfigBits = vecs[v].cfg;
            bus.CfgActive  = vecs[v].act;
            hold_cycles(vecs[v].hold, pulses);
            chk($sformatf("vec%0d_cbit", v), {24'd0, bus.C_bit}, {24'd0, vecs[v].exp_c});
            chk($sformatf("vec%0d_pulses", v), pulses, vecs[v].exp_pulses);
        end

        // Exact update latency 00 -> 3C: visible on the 7th edge, pulse for one cycle.
        bus.ConfigBits = 8'h00;
        hold_cycles(12, pulses);
        chk("lat_pre", {24'd0, bus.C_bit}, 32'h00);
        bus.ConfigBits = 8'h3C;
        for (int c = 1; c <= 8; c++) begin
            step();
            chk($sformatf("lat_cbit_c%0d", c), {24'd0, bus.C_bit}, (c >= 7) ? 32'h3C : 32'h00);
            chk($sformatf("lat_chg_c%0d", c), {31'd0, bus.C_changed}, (c == 7) ? 32'd1 : 32'd0);
        end

        // Freeze: toggling under CfgActive never reaches C_bit.
        bus.CfgActive = 1'b1;
        for (int c = 0; c < 20; c++) begin
            bus.ConfigBits = (c % 2 == 0) ? 8'h22 : 8'h11;
            step();
            chk("frz_cbit", {24'd0, bus.C_bit}, 32'h3C);
            chk("frz_chg",  {31'd0, bus.C_changed}, 32'd0);
        end
        bus.ConfigBits = 8'h22;
        bus.CfgActive  = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            step();
            chk($sformatf("frz_rel_c%0d", c), {24'd0, bus.C_bit}, (c == 7) ? 32'h22 : 32'h3C);
        end

        // Readback of B4 with a mid-stream update to 00.
        bus.ConfigBits = 8'hB4;
        hold_cycles(10, pulses);
        chk("rb_setup", {24'd0, bus.C_bit}, 32'hB4);
        bus.ConfigBits = 8'h00;
        step();
        step();
        check_stream(8'hB4, "rb");
        chk("rb_after_upd", {24'd0, bus.C_bit}, 32'h00);

        // Reset in the middle of a readback.
        bus.ConfigBits = 8'hB4;
        hold_cycles(10, pulses);
        snap = 8'hB4;
        bus.ser_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            bus.ser_start = 1'b0;
            chk("rst_mid_data", {31'd0, bus.ser_data}, {31'd0, snap[i]});
        end
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_valid", {31'd0, bus.ser_valid}, 32'd0);
        chk("rst_mid_cbit",  {24'd0, bus.C_bit}, {24'd0, RV});
        step();
        rst = 1'b0;
        step();
        chk("rst_mid_valid2", {31'd0, bus.ser_valid}, 32'd0);
        hold_cycles(15, pulses);
        chk("rst_mid_recover", {24'd0, bus.C_bit}, 32'hB4);
        check_stream(8'hB4, "rb_post_rst");

        // Back-to-back readbacks with ser_start held: one idle cycle between streams.
        bus.ConfigBits = 8'h5A;
        hold_cycles(12, pulses);
        snap = 8'h5A;
        bus.ser_start = 1'b1;
        for (int c = 0; c < 17; c++) begin
            step();
            chk($sformatf("b2b_valid_c%0d", c), {31'd0, bus.ser_valid}, (c == 8) ? 32'd0 : 32'd1);
            if (c != 8) begin
                chk("b2b_data", {31'd0, bus.ser_data}, {31'd0, snap[(c < 8) ? c : c - 9]});
            end
        end
        bus.ser_start = 1'b0;
        repeat (9) step();
        chk("b2b_end", {31'd0, bus.ser_valid}, 32'd0);

        // Random stimulus against a history-based reference model.
        pool[0] = 8'h00; pool[1] = 8'h5A; pool[2] = 8'hC3; pool[3] = 8'h5B;
        bus.ConfigBits = 8'h5A;
        bus.CfgActive  = 1'b0;
        repeat (12) step();
        for (int i = 0; i < 12; i++) begin
            in_h.push_back(8'h5A);
            act_h.push_back(1'b0);
        end
        model_c   = 8'h5A;
        hold_left = 0;
        act_left  = 0;
        cur_v     = 8'h5A;
        for (int it = 0; it < 400; it++) begin
            if (hold_left == 0) begin
                cur_v     = pool[$urandom_range(0, 3)];
                hold_left = $urandom_range(1, 9);
            end
            hold_left--;
            if (act_left > 0) begin
                act_left--;
            end else if ($urandom_range(0, 99) < 10) begin
                act_left = $urandom_range(1, 6);
            end
            bus.ConfigBits = cur_v;
            bus.CfgActive  = (act_left > 0);
            in_h.push_back(cur_v);
            act_h.push_back(act_left > 0);
            step();
            // C_bit takes the synced word seen two edges ago once it has been
            // equal for S+1 samples with CfgActive low for the last S of them.
            k   = in_h.size() - 1;
            upd = 1'b1;
            for (int m = 0; m <= S; m++) begin
                if (in_h[k-2-m] != in_h[k-2]) upd = 1'b0;
            end
            for (int m = 0; m < S; m++) begin
                if (act_h[k-2-m]) upd = 1'b0;
            end
            if (in_h[k-2] == model_c) upd = 1'b0;
            if (upd) model_c = in_h[k-2];
            chk("rnd_cbit",    {24'd0, bus.C_bit}, {24'd0, model_c});
            chk("rnd_changed", {31'd0, bus.C_changed}, {31'd0, upd});
            chk("rnd_valid",   {31'd0, bus.ser_valid}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
